// File: rtl/pc_sequencer.sv
// PC register and instruction-fetch sequencer: req/ack IM fetch, delayed-slot redirects, stall and exceptions.
// Optional macro PCSEQ_ALIGN_CHK_EN adds align_err and traps misaligned redirect targets.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out,
    output logic [1:0]  npc_op,
    input  logic [31:0] npc_in,
    input  logic        br_valid,
    input  logic [1:0]  br_op,
    input  logic        stall,
    output logic        im_req,
    input  logic        im_ack,
    output logic        if_valid,
    input  logic        exc_req,
    output logic [31:0] epc,
    output logic        redir_drop
`ifdef PCSEQ_ALIGN_CHK_EN
    ,
    output logic        align_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [31:0] pc_d, epc_d, pend_tgt, pend_tgt_d;
    logic        pend_v, pend_v_d;
    logic        align_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            pc_out   <= RESET_PC;
            epc      <= '0;
            pend_v   <= 1'b0;
            pend_tgt <= '0;
        end else begin
            state    <= state_d;
            pc_out   <= pc_d;
            epc      <= epc_d;
            pend_v   <= pend_v_d;
            pend_tgt <= pend_tgt_d;
        end
    end

`ifdef PCSEQ_ALIGN_CHK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) align_err <= 1'b0;
        else       align_err <= align_d;
    end
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state;
        pc_d       = pc_out;
        epc_d      = epc;
        pend_v_d   = pend_v;
        pend_tgt_d = pend_tgt;
        im_req     = 1'b0;
        if_valid   = 1'b0;
        redir_drop = 1'b0;
        align_d    = 1'b0;
        npc_op     = br_valid ? br_op : 2'b00;

        case (state)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                im_req = 1'b1;
                if (im_ack) state_d = S_VALID;
            end
            S_VALID: begin
                if_valid = 1'b1;
                if (!stall) begin
                    state_d = S_FETCH;
                    if (pend_v) begin
                        pc_d     = pend_tgt;
                        pend_v_d = 1'b0;
`ifdef PCSEQ_ALIGN_CHK_EN
                        if (pend_tgt[1:0] != 2'b00) begin
                            epc_d   = pend_tgt;
                            pc_d    = EXC_VECTOR;
                            state_d = S_IDLE;
                            align_d = 1'b1;
                        end
`endif
                    end else begin
                        pc_d = pc_out + 32'd4;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect capture; a second redirect while one is pending is dropped.
        if (state != S_IDLE && br_valid) begin
            if (pend_v) begin
                redir_drop = 1'b1;
            end else begin
                pend_tgt_d = npc_in;
                pend_v_d   = 1'b1;
`ifdef PCSEQ_ALIGN_CHK_EN
                if (npc_in[1:0] != 2'b00) begin
                    epc_d    = npc_in;
                    pc_d     = EXC_VECTOR;
                    pend_v_d = 1'b0;
                    state_d  = S_IDLE;
                    align_d  = 1'b1;
                end
`endif
            end
        end

        // Exception overrides any acceptance, ack or redirect in the same cycle.
        if (state != S_IDLE && exc_req) begin
            epc_d      = pc_out;
            pc_d       = EXC_VECTOR;
            pend_v_d   = 1'b0;
            state_d    = S_IDLE;
            redir_drop = 1'b0;
            align_d    = 1'b0;
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch through a req/ack instruction-memory interface.
- Drives the 2-bit next-PC select to the next-PC unit and captures its computed redirect target.
- Applies redirects (j/branch) after one delay-slot instruction; handles decode-stage stall and exception redirect.
- Sits between the hazard/decode logic, the next-PC unit and the IM, feeding the IF/ID register.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
EXC_VECTOR, 32'h0000_4180, PC loaded on exception

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
pc_out  output  32  current fetch PC; to IM address and next-PC unit PC input
npc_op  output  2  select to next-PC unit: br_op when br_valid=1, else 2'b00
npc_in  input  32  next-PC unit result
br_valid  input  1  one-cycle pulse: decode has resolved a control-flow instruction
br_op  input  2  next-PC select for that instruction (01 j, 10 rs-cond, 11 rel)
stall  input  1  IF/ID cannot accept an instruction this cycle
im_req  output  1  fetch request at pc_out
im_ack  input  1  IM data valid for the current request
if_valid  output  1  fetched instruction valid toward IF/ID
exc_req  input  1  exception redirect request (pulse)
epc  output  32  PC captured on exception
redir_drop  output  1  one-cycle pulse: br_valid ignored because a redirect is already pending

Behaviour:
- Reset state: pc_out=RESET_PC, epc=0, state S_IDLE, im_req=0, if_valid=0, redir_drop=0, pend_v=0, pend_tgt=0.
- Reset asserted mid-fetch abandons the request immediately; im_req drops asynchronously.
- S_IDLE: im_req=0, if_valid=0; next state S_FETCH unconditionally.
- S_FETCH: im_req=1, pc_out stable.
  - im_ack=1: go to S_VALID.
  - im_ack=0: stay; wait states are unbounded.
- S_VALID: if_valid=1, im_req=0. Acceptance occurs when stall=0.
  - On acceptance, pc_out <= pend_tgt if pend_v=1 (and pend_v <= 0), else pc_out+4 (internal 32-bit adder, wraps modulo 2^32). Next state S_FETCH.
  - stall=1: hold all state; if_valid stays 1.
- Throughput: 2 cycles/instruction with zero-wait IM and no stall.
- Redirect capture, any state except S_IDLE:
  - npc_op=br_op combinationally during the br_valid cycle.
  - On that edge, pend_tgt <= npc_in and pend_v <= 1.
  - The next accepted instruction (delay slot) completes sequentially; the PC update after it loads pend_tgt.
- br_valid in the same cycle as an acceptance with pend_v=0:
  - The current acceptance advances to pc+4.
  - The target is captured and applied at the following acceptance.
- br_valid with pend_v=1: ignored, pend unchanged, redir_drop=1 for that cycle.
- Exception: exc_req=1 in any state except S_IDLE has top priority.
  - epc <= pc_out; pc_out <= EXC_VECTOR; pend_v <= 0; state <= S_IDLE.
  - A simultaneous im_ack, acceptance or br_valid is discarded; redir_drop stays 0.
- Priority: reset > exc_req > acceptance/redirect capture > hold.
- npc_op=00 whenever br_valid=0.

Optional Feature:
- Macro: PCSEQ_ALIGN_CHK_EN.
- Defined:
  - Adds output align_err (1 bit, reset 0).
  - Any value about to load into pc_out (pend_tgt or captured npc_in) with bits [1:0] != 0 is treated as an exception: epc <= offending target, pc_out <= EXC_VECTOR, state S_IDLE, align_err=1 for one cycle.
  - The check on a captured npc_in fires at capture time.
- Undefined: no port; targets loaded unchecked (low bits kept as is).

Test Plan:
- Reset release, im_ack tied 1, stall 0 -> im_req first at cycle 1 with pc_out=0x3000; if_valid pulses every 2 cycles; pc_out 0x3000,0x3004,0x3008.
- im_ack delayed 3 cycles at pc 0x3004 -> pc_out, im_req held 3 cycles; if_valid only after ack; no PC change.
- stall=1 for 4 cycles in S_VALID at 0x3008 -> if_valid held 1, pc_out stays 0x3008; advances to 0x300C the cycle after stall drops.
- br_valid with br_op=01, npc_in=0x3400, while pc_out=0x3010 -> npc_op=01 that cycle; next accepted instruction at 0x3010; following fetch pc_out=0x3400; second br_valid before then -> redir_drop=1, target still 0x3400.
- exc_req during S_FETCH at 0x3020 with simultaneous im_ack -> epc=0x3020, pc_out=0x4180, one S_IDLE cycle, if_valid never asserts for 0x3020, pending redirect cleared.
- PCSEQ_ALIGN_CHK_EN defined, br_valid npc_in=0x3402 -> align_err pulse, epc=0x3402, pc_out=0x4180.
